// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache, 16-byte lines.
// Hits answer in one cycle; misses refill a whole line from the bridge.
module icache_dm #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 28 - INDEX_WIDTH;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_LOOKUP  = 5'b00010,
        S_MISS    = 5'b00100,
        S_REFILL  = 5'b01000,
        S_RESPOND = 5'b10000
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]            req_addr;
    logic [1:0]             cnt;
    logic [LINES-1:0]       valid;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [31:0]            data_mem [LINES*4];

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_W-1:0]       req_tag;
    logic [1:0]             off;
    logic                   hit;
    logic                   accept;
    logic                   refill_beat;
    logic                   refill_done;
    logic                   unused_addr_bits;

    assign idx     = req_addr[3+INDEX_WIDTH:4];
    assign req_tag = req_addr[31:4+INDEX_WIDTH];
    assign off     = req_addr[3:2];
    assign hit     = valid[idx] && (tag_mem[idx] == req_tag);
    assign accept  = cpu_req && cpu_addr_ok;

    assign refill_beat = (state == S_REFILL) && ret_valid;
    assign refill_done = refill_beat && ret_last;

    assign unused_addr_bits = ^req_addr[1:0];

    assign rd_type   = 3'b100;
    assign rd_addr   = {req_addr[31:4], 4'b0000};
    assign cpu_rdata = data_mem[{idx, off}];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            req_addr <= '0;
            cnt      <= '0;
            valid    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                req_addr <= cpu_addr;
            end
            if ((state == S_MISS) && rd_rdy) begin
                cnt <= '0;
            end else if (refill_beat) begin
                cnt <= cnt + 2'd1;
            end
            if (refill_done) begin
                valid[idx] <= 1'b1;
            end
        end
    end

    // Arrays carry no reset; a reset cycle must not commit a stray beat.
    always_ff @(posedge aclk) begin
        if (aresetn && refill_beat) begin
            data_mem[{idx, cnt}] <= ret_data;
        end
        if (aresetn && refill_done) begin
            tag_mem[idx] <= req_tag;
        end
    end

    always_comb begin
        next_state  = state;
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        rd_req      = 1'b0;
        unique case (state)
            S_IDLE: begin
                cpu_addr_ok = 1'b1;
                if (cpu_req) begin
                    next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    cpu_data_ok = 1'b1;
                    cpu_addr_ok = 1'b1;
                    next_state  = cpu_req ? S_LOOKUP : S_IDLE;
                end else begin
                    next_state = S_MISS;
                end
            end
            S_MISS: begin
                rd_req = 1'b1;
                if (rd_rdy) begin
                    next_state = S_REFILL;
                end
            end
            S_REFILL: begin
                if (ret_valid && ret_last) begin
                    next_state = S_RESPOND;
                end
            end
            S_RESPOND: begin
                cpu_data_ok = 1'b1;
                next_state  = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule
